ahb_lite_master: RTL and testbench

Single-master AHB-Lite initiator: converts a valid/ready command stream into pipelined AHB single (NONSEQ) transfers and returns one response per command, in order. It drives the bus side of AHB slaves such as the on-chip SRAM memory and tolerates slave wait states (HREADYOUT low) and two-cycle ERROR responses. One command can sit in the address phase while the previous one is in its data phase, giving one transfer per cycle with zero-wait slaves.

---
 rtl/ahb_lite_master_if.sv | 45 ++++
 rtl/ahb_lite_master.sv | 103 ++++++++++
 tb/tb_ahb_lite_master.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_master_if.sv
// Command/response stream plus AHB-Lite bus signals of the single-master initiator.
// The master modport is the initiator's view; the slave modport is the far side.
interface ahb_lite_master_if #(
    parameter int AW = 32
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [1:0]    cmd_size;
    logic [31:0]   cmd_wdata;

    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          idle;

    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [2:0]    HBURST;
    logic [3:0]    HPROT;
    logic          HMASTLOCK;
    logic [31:0]   HWDATA;
    logic [31:0]   HRDATA;
    logic          HREADY;
    logic          HRESP;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, idle,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, idle,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-master initiator: valid/ready commands become pipelined NONSEQ
// single transfers with one in-order response per command.
module ahb_lite_master #(
    parameter int AW = 32
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahb_lite_master_if.master  bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // address-phase register
    logic          a_valid;
    logic [AW-1:0] a_addr;
    logic          a_write;
    logic [1:0]    a_size;
    logic [31:0]   a_wdata;

    // data-phase register; hwdata doubles as the lane-replicated write data
    logic          d_valid;
    logic          d_write;
    logic [31:0]   hwdata;

    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [31:0]   rsp_rdata_q;

    logic          a_adv;
    logic          d_done;
    logic          cmd_ready_c;
    logic          accept;

    function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] w);
        case (size)
            2'd0:    return {4{w[7:0]}};
            2'd1:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    assign a_adv       = a_valid & bus.HREADY & ~bus.HRESP;
    assign d_done      = d_valid & bus.HREADY;
    assign cmd_ready_c = ~HRESET & ~bus.HRESP & (~a_valid | bus.HREADY);
    assign accept      = bus.cmd_valid & cmd_ready_c;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            a_valid     <= 1'b0;
            a_addr      <= '0;
            a_write     <= 1'b0;
            a_size      <= 2'd0;
            a_wdata     <= 32'h0;
            d_valid     <= 1'b0;
            d_write     <= 1'b0;
            hwdata      <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            // accept implies A is empty or leaving this edge, so A never overwrites a live command
            if (accept) begin
                a_valid <= 1'b1;
                a_addr  <= bus.cmd_addr;
                a_write <= bus.cmd_write;
                a_size  <= bus.cmd_size;
                a_wdata <= bus.cmd_wdata;
            end else if (a_adv) begin
                a_valid <= 1'b0;
            end

            if (a_adv) begin
                d_valid <= 1'b1;
                d_write <= a_write;
                hwdata  <= lane_rep(a_size, a_wdata);
            end else if (d_done) begin
                d_valid <= 1'b0;
            end

            rsp_valid_q <= d_done;
            rsp_err_q   <= d_done & bus.HRESP;
            if (d_done) begin
                rsp_rdata_q <= d_write ? 32'h0 : bus.HRDATA;
            end
        end
    end

    // an ERROR in the data phase masks the pending address phase for both cycles
    assign bus.HTRANS    = (a_valid & ~(d_valid & bus.HRESP)) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HADDR     = a_addr;
    assign bus.HWRITE    = a_write;
    assign bus.HSIZE     = {1'b0, a_size};
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = 4'b0011;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = hwdata;

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.idle      = ~a_valid & ~d_valid;
endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: scripted AHB slave with per-transfer waits/errors,
// address-phase and response scoreboards, table-driven commands plus corner sequences.
module tb_ahb_lite_master;
    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        int          waits;
        logic        err;
        logic [31:0] exp_hwdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic HCLK;
    logic HRESET;
    logic idle_pulse;

    int vectors;
    int miscompares;

    vec_t bus_q[$];
    rsp_t rsp_q[$];

    vec_t dp_e;
    logic dp_active;
    int   wait_cnt;
    logic err_stage;

    localparam int NV = 12;
    vec_t tbl[NV];
    vec_t v;

    ahb_lite_master_if #(.AW(32)) bus ();

    ahb_lite_master #(.AW(32)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [31:0] slv_rdata(input logic [31:0] addr);
        if (addr == 32'h100) return 32'hDEADBEEF;
        return {~addr[15:0], addr[15:0]};
    endfunction

    // slave: combinational response from the captured data-phase entry
    always_comb begin
        bus.HREADY = 1'b1;
        bus.HRESP  = idle_pulse;
        bus.HRDATA = 32'h0;
        if (dp_active) begin
            if (dp_e.err) begin
                bus.HRESP  = 1'b1;
                bus.HREADY = err_stage;
            end else begin
                bus.HREADY = (wait_cnt == 0);
            end
            bus.HRDATA = dp_e.write ? 32'hBAD0BAD0 : slv_rdata(dp_e.addr);
        end
    end

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_active <= 1'b0;
            wait_cnt  <= 0;
            err_stage <= 1'b0;
        end else begin
            if (dp_active && bus.HREADY && dp_e.write)
                chk("hwdata", bus.HWDATA, dp_e.exp_hwdata);
            if (dp_active && !bus.HREADY) begin
                if (dp_e.err) err_stage <= 1'b1;
                else if (wait_cnt > 0) wait_cnt <= wait_cnt - 1;
            end
            if (bus.HREADY) begin
                dp_active <= 1'b0;
                if (bus.HTRANS == 2'b10) begin
                    if (bus_q.size() == 0) begin
                        note_fail("unexpected_nonseq", "NONSEQ with no command outstanding");
                    end else begin
                        chk("haddr", bus.HADDR, bus_q[0].addr);
                        chk("hwrite", {31'h0, bus.HWRITE}, {31'h0, bus_q[0].write});
                        chk("hsize", {29'h0, bus.HSIZE}, {29'h0, 1'b0, bus_q[0].size});
                        dp_e      <= bus_q[0];
                        dp_active <= 1'b1;
                        wait_cnt  <= bus_q[0].waits;
                        err_stage <= 1'b0;
                        void'(bus_q.pop_front());
                    end
                end
            end
        end
    end

    // response scoreboard
    always @(negedge HCLK) begin
        if (bus.rsp_valid) begin
            if (rsp_q.size() == 0) begin
                note_fail("unexpected_rsp", "rsp_valid=1 with no response expected");
            end else begin
                chk("rsp_rdata", bus.rsp_rdata, rsp_q[0].rdata);
                chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, rsp_q[0].err});
                void'(rsp_q.pop_front());
            end
        end
    end

    task automatic push_exp(input vec_t e);
        rsp_t r;
        r.rdata = e.exp_rdata;
        r.err   = e.err;
        bus_q.push_back(e);
        rsp_q.push_back(r);
    endtask

    task automatic drive_cmd(input vec_t e);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = e.write;
        bus.cmd_addr  = e.addr;
        bus.cmd_size  = e.size;
        bus.cmd_wdata = e.wdata;
    endtask

    // called just after a rising edge; returns just after the accepting edge
    task automatic issue(input vec_t e);
        logic r;
        bit   done;
        done = 0;
        drive_cmd(e);
        push_exp(e);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge HCLK);
            r = bus.cmd_ready;
            @(posedge HCLK);
            #1;
            if (r) done = 1;
        end
        bus.cmd_valid = 1'b0;
        if (!done) note_fail("accept_timeout", "cmd_ready never seen within 50 cycles");
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge HCLK);
            if (bus.idle && rsp_q.size() == 0 && bus_q.size() == 0) ok = 1;
        end
        if (!ok) note_fail("idle_timeout", "outstanding work after 200 cycles");
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors       = 0;
        miscompares   = 0;
        idle_pulse    = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_size  = 2'd0;
        bus.cmd_wdata = 32'h0;

        //          write addr          size  wdata          waits err  exp_hwdata     exp_rdata
        tbl[0]  = '{1'b1, 32'h0000_0000, 2'd2, 32'h1111_1111, 1, 1'b0, 32'h1111_1111, 32'h0};
        tbl[1]  = '{1'b1, 32'h0000_0004, 2'd2, 32'h2222_2222, 1, 1'b0, 32'h2222_2222, 32'h0};
        tbl[2]  = '{1'b1, 32'h0000_0008, 2'd2, 32'h3333_3333, 1, 1'b0, 32'h3333_3333, 32'h0};
        tbl[3]  = '{1'b1, 32'h0000_000C, 2'd2, 32'h4444_4444, 1, 1'b0, 32'h4444_4444, 32'h0};
        tbl[4]  = '{1'b1, 32'h0000_0003, 2'd0, 32'hFFFF_FF5A, 0, 1'b0, 32'h5A5A_5A5A, 32'h0};
        tbl[5]  = '{1'b1, 32'h0000_0002, 2'd1, 32'hABCD_1234, 0, 1'b0, 32'h1234_1234, 32'h0};
        tbl[6]  = '{1'b0, 32'h0000_0200, 2'd2, 32'h0,         0, 1'b0, 32'h0,         32'hFDFF_0200};
        tbl[7]  = '{1'b0, 32'h0000_0204, 2'd2, 32'h0,         0, 1'b0, 32'h0,         32'hFDFB_0204};
        tbl[8]  = '{1'b0, 32'h0000_0208, 2'd2, 32'h0,         2, 1'b0, 32'h0,         32'hFDF7_0208};
        tbl[9]  = '{1'b0, 32'h0000_0001, 2'd0, 32'h0,         0, 1'b0, 32'h0,         32'hFFFE_0001};
        tbl[10] = '{1'b1, 32'h0000_0020, 2'd3, 32'h89AB_CDEF, 0, 1'b0, 32'h89AB_CDEF, 32'h0};
        tbl[11] = '{1'b1, 32'h0000_0024, 2'd1, 32'h0000_BEEF, 3, 1'b0, 32'hBEEF_BEEF, 32'h0};

        // reset values
        HRESET = 1'b1;
        #12;
        chk("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
        chk("rst_idle", {31'h0, bus.idle}, 32'h1);
        chk("rst_htrans", {30'h0, bus.HTRANS}, 32'h0);
        chk("rst_haddr", bus.HADDR, 32'h0);
        chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("hprot", {28'h0, bus.HPROT}, 32'h3);
        chk("hburst", {29'h0, bus.HBURST}, 32'h0);
        chk("hmastlock", {31'h0, bus.HMASTLOCK}, 32'h0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;

        // single zero-wait read: NONSEQ in cycle 1, response in cycle 3
        v = '{1'b0, 32'h100, 2'd2, 32'h0, 0, 1'b0, 32'h0, 32'hDEADBEEF};
        drive_cmd(v);
        push_exp(v);
        @(negedge HCLK);
        chk("rd_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
        @(posedge HCLK);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge HCLK);
        chk("rd_c1_htrans", {30'h0, bus.HTRANS}, 32'h2);
        chk("rd_c1_haddr", bus.HADDR, 32'h100);
        chk("rd_c1_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        @(negedge HCLK);
        chk("rd_c2_htrans", {30'h0, bus.HTRANS}, 32'h0);
        chk("rd_c2_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        @(negedge HCLK);
        chk("rd_c3_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
        chk("rd_c3_idle", {31'h0, bus.idle}, 32'h1);
        @(posedge HCLK);
        #1;
        wait_idle();

        // table: back-to-back commands with waits, sizes and lane replication
        for (int i = 0; i < NV; i++) issue(tbl[i]);
        wait_idle();

        // ERROR on a write while a read waits in the address phase
        v = '{1'b1, 32'h300, 2'd2, 32'h0BAD_F00D, 0, 1'b1, 32'h0BAD_F00D, 32'h0};
        issue(v);
        v = '{1'b0, 32'h304, 2'd2, 32'h0, 0, 1'b0, 32'h0, 32'hFCFB_0304};
        drive_cmd(v);
        push_exp(v);
        @(negedge HCLK);
        chk("err_c1_htrans", {30'h0, bus.HTRANS}, 32'h2);
        chk("err_c1_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
        @(posedge HCLK);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge HCLK);
        chk("err_e1_htrans", {30'h0, bus.HTRANS}, 32'h0);
        chk("err_e1_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
        @(negedge HCLK);
        chk("err_e2_htrans", {30'h0, bus.HTRANS}, 32'h0);
        chk("err_e2_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
        @(negedge HCLK);
        chk("err_reissue_htrans", {30'h0, bus.HTRANS}, 32'h2);
        chk("err_reissue_haddr", bus.HADDR, 32'h304);
        chk("err_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
        @(posedge HCLK);
        #1;
        wait_idle();

        // reset with both A and D occupied
        v = '{1'b1, 32'h40, 2'd2, 32'hCAFE_F00D, 3, 1'b0, 32'hCAFE_F00D, 32'h0};
        issue(v);
        v = '{1'b0, 32'h44, 2'd2, 32'h0, 0, 1'b0, 32'h0, 32'hFFBB_0044};
        issue(v);
        chk("pre_rst_idle", {31'h0, bus.idle}, 32'h0);
        chk("pre_rst_hwdata", bus.HWDATA, 32'hCAFE_F00D);
        HRESET = 1'b1;
        #1;
        bus_q.delete();
        rsp_q.delete();
        chk("mid_rst_htrans", {30'h0, bus.HTRANS}, 32'h0);
        chk("mid_rst_haddr", bus.HADDR, 32'h0);
        chk("mid_rst_hwrite", {31'h0, bus.HWRITE}, 32'h0);
        chk("mid_rst_hwdata", bus.HWDATA, 32'h0);
        chk("mid_rst_idle", {31'h0, bus.idle}, 32'h1);
        chk("mid_rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("post_rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
        @(posedge HCLK);
        #1;
        v = '{1'b0, 32'h180, 2'd2, 32'h0, 0, 1'b0, 32'h0, 32'hFE7F_0180};
        issue(v);
        wait_idle();

        // HRESP pulse with nothing in flight
        idle_pulse = 1'b1;
        @(negedge HCLK);
        chk("pulse_htrans", {30'h0, bus.HTRANS}, 32'h0);
        chk("pulse_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
        chk("pulse_idle", {31'h0, bus.idle}, 32'h1);
        @(posedge HCLK);
        #1;
        idle_pulse = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        v = '{1'b0, 32'h1FC, 2'd2, 32'h0, 0, 1'b0, 32'h0, 32'hFE03_01FC};
        issue(v);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
